// File: rtl/fp_cvt_arbiter.sv
// Round-robin arbiter sharing one fp_converter between two requesters.
// Screens illegal ops, resolves dynamic rounding, and returns a tagged response
// with fflags. A watchdog bounds the wait for the converter, and flush drops
// the in-flight work.
module fp_cvt_arbiter #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned FLEN    = 32,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [3:0]       i_req0_op,
  input  logic [2:0]       i_req0_rm,
  input  logic [XLEN-1:0]  i_req0_int,
  input  logic [FLEN-1:0]  i_req0_fp,
  input  logic [TAG_W-1:0] i_req0_tag,
  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [3:0]       i_req1_op,
  input  logic [2:0]       i_req1_rm,
  input  logic [XLEN-1:0]  i_req1_int,
  input  logic [FLEN-1:0]  i_req1_fp,
  input  logic [TAG_W-1:0] i_req1_tag,
  input  logic [2:0]       i_frm,
  input  logic             i_flush,
  output logic             o_cvt_start,
  output logic [3:0]       o_cvt_op,
  output logic [2:0]       o_cvt_rm,
  output logic [XLEN-1:0]  o_cvt_int_op,
  output logic [FLEN-1:0]  o_cvt_fp_op,
  input  logic             i_cvt_done,
  input  logic [XLEN-1:0]  i_cvt_int_res,
  input  logic [FLEN-1:0]  i_cvt_fp_res,
  input  logic             i_cvt_nv,
  input  logic             i_cvt_nx,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic             o_rsp_id,
  output logic [TAG_W-1:0] o_rsp_tag,
  output logic [XLEN-1:0]  o_rsp_int,
  output logic [FLEN-1:0]  o_rsp_fp,
  output logic [4:0]       o_rsp_fflags,
  output logic             o_rsp_err,
  output logic [4:0]       o_fflags_acc,
  input  logic             i_fflags_clr
);

  localparam int unsigned TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [4:0]  FF_NV = 5'b10000;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_DRAIN} state_t;

  state_t             r_state, w_next;
  logic               r_last_grant;
  logic [TMR_W-1:0]   r_timer;
  logic               r_cvt_start;
  logic [3:0]         r_cvt_op;
  logic [2:0]         r_cvt_rm;
  logic [XLEN-1:0]    r_cvt_int_op;
  logic [FLEN-1:0]    r_cvt_fp_op;
  logic               r_rsp_valid;
  logic               r_rsp_id;
  logic [TAG_W-1:0]   r_rsp_tag;
  logic [XLEN-1:0]    r_rsp_int;
  logic [FLEN-1:0]    r_rsp_fp;
  logic [4:0]         r_rsp_fflags;
  logic               r_rsp_err;
  logic [4:0]         r_fflags_acc;

  logic               w_pick1, w_idle_ok, w_gnt0, w_gnt1, w_gnt;
  logic [3:0]         w_sel_op;
  logic [2:0]         w_sel_rm, w_eff_rm;
  logic               w_op_bad, w_illegal, w_tmo, w_hs;

  // Request selection: req1 wins only when req0 is idle or req0 was granted last
  assign w_pick1   = i_req1_valid & (~i_req0_valid | ~r_last_grant);
  assign w_idle_ok = (r_state == S_IDLE) & ~i_flush;
  assign w_gnt0    = w_idle_ok & i_req0_valid & ~w_pick1;
  assign w_gnt1    = w_idle_ok & w_pick1;
  assign w_gnt     = w_gnt0 | w_gnt1;
  assign w_sel_op  = w_pick1 ? i_req1_op : i_req0_op;
  assign w_sel_rm  = w_pick1 ? i_req1_rm : i_req0_rm;
  assign w_eff_rm  = (w_sel_rm == 3'b111) ? i_frm : w_sel_rm;
  assign w_op_bad  = (w_sel_op > 4'd9)
                   | ((XLEN == 32) & ((w_sel_op == 4'd2) | (w_sel_op == 4'd3) |
                                      (w_sel_op == 4'd6) | (w_sel_op == 4'd7)))
                   | ((FLEN == 32) & ((w_sel_op == 4'd8) | (w_sel_op == 4'd9)));
  // Resolved rm 101..111 covers static 101/110 and dynamic frm 101..111
  assign w_illegal = w_op_bad | (w_eff_rm >= 3'b101);
  assign w_tmo     = (r_timer == TMR_W'(TIMEOUT - 1));
  assign w_hs      = (r_state == S_RESP) & i_rsp_ready & ~i_flush;

  assign o_req0_ready = w_gnt0;
  assign o_req1_ready = w_gnt1;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic; flush takes priority over grant, done and handshake
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_gnt) w_next = w_illegal ? S_RESP : S_ISSUE;
      S_ISSUE: w_next = i_flush ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        if (i_flush)                 w_next = i_cvt_done ? S_IDLE : S_DRAIN;
        else if (i_cvt_done | w_tmo) w_next = S_RESP;
      end
      S_RESP:  if (i_flush | i_rsp_ready) w_next = S_IDLE;
      S_DRAIN: if (i_cvt_done | w_tmo)    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: operand latching, start pulse, watchdog, response and sticky flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= 1'b1;
      r_timer      <= '0;
      r_cvt_start  <= 1'b0;
      r_cvt_op     <= '0;
      r_cvt_rm     <= '0;
      r_cvt_int_op <= '0;
      r_cvt_fp_op  <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_tag    <= '0;
      r_rsp_int    <= '0;
      r_rsp_fp     <= '0;
      r_rsp_fflags <= '0;
      r_rsp_err    <= 1'b0;
      r_fflags_acc <= '0;
    end else begin
      r_cvt_start <= 1'b0;
      if (w_gnt) begin
        r_last_grant <= w_pick1;
        r_cvt_op     <= w_sel_op;
        r_cvt_rm     <= w_eff_rm;
        r_cvt_int_op <= w_pick1 ? i_req1_int : i_req0_int;
        r_cvt_fp_op  <= w_pick1 ? i_req1_fp  : i_req0_fp;
        r_rsp_id     <= w_pick1;
        r_rsp_tag    <= w_pick1 ? i_req1_tag : i_req0_tag;
        r_cvt_start  <= ~w_illegal;
        if (w_illegal) begin
          r_rsp_valid  <= 1'b1;
          r_rsp_err    <= 1'b1;
          r_rsp_fflags <= FF_NV;
          r_rsp_int    <= '0;
          r_rsp_fp     <= '0;
        end
      end
      if (r_state == S_ISSUE) r_timer <= '0;
      else if ((r_state == S_WAIT) || (r_state == S_DRAIN)) r_timer <= r_timer + TMR_W'(1);
      if ((r_state == S_WAIT) && !i_flush) begin
        if (i_cvt_done) begin
          r_rsp_valid  <= 1'b1;
          r_rsp_err    <= 1'b0;
          r_rsp_fflags <= {i_cvt_nv, 3'b000, i_cvt_nx};
          r_rsp_int    <= i_cvt_int_res;
          r_rsp_fp     <= i_cvt_fp_res;
        end else if (w_tmo) begin
          r_rsp_valid  <= 1'b1;
          r_rsp_err    <= 1'b1;
          r_rsp_fflags <= FF_NV;
          r_rsp_int    <= '0;
          r_rsp_fp     <= '0;
        end
      end
      if ((r_state == S_RESP) && (i_flush || i_rsp_ready)) r_rsp_valid <= 1'b0;
      if (i_fflags_clr)  r_fflags_acc <= w_hs ? r_rsp_fflags : 5'b00000;
      else if (w_hs)     r_fflags_acc <= r_fflags_acc | r_rsp_fflags;
    end
  end

  assign o_cvt_start  = r_cvt_start;
  assign o_cvt_op     = r_cvt_op;
  assign o_cvt_rm     = r_cvt_rm;
  assign o_cvt_int_op = r_cvt_int_op;
  assign o_cvt_fp_op  = r_cvt_fp_op;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_id     = r_rsp_id;
  assign o_rsp_tag    = r_rsp_tag;
  assign o_rsp_int    = r_rsp_int;
  assign o_rsp_fp     = r_rsp_fp;
  assign o_rsp_fflags = r_rsp_fflags;
  assign o_rsp_err    = r_rsp_err;
  assign o_fflags_acc = r_fflags_acc;

endmodule

// File: tb/tb_fp_cvt_arbiter.sv
// Directed bench for fp_cvt_arbiter with a three-cycle converter model.
module tb_fp_cvt_arbiter;
  localparam int unsigned XLEN = 32;
  localparam int unsigned FLEN = 32;
  localparam int unsigned TAG_W = 4;

  logic clk, reset_n;
  logic i_req0_valid, o_req0_ready, i_req1_valid, o_req1_ready;
  logic [3:0] i_req0_op, i_req1_op;
  logic [2:0] i_req0_rm, i_req1_rm, i_frm;
  logic [XLEN-1:0] i_req0_int, i_req1_int;
  logic [FLEN-1:0] i_req0_fp, i_req1_fp;
  logic [TAG_W-1:0] i_req0_tag, i_req1_tag;
  logic i_flush, o_cvt_start;
  logic [3:0] o_cvt_op;
  logic [2:0] o_cvt_rm;
  logic [XLEN-1:0] o_cvt_int_op, i_cvt_int_res, o_rsp_int;
  logic [FLEN-1:0] o_cvt_fp_op, i_cvt_fp_res, o_rsp_fp;
  logic i_cvt_done, i_cvt_nv, i_cvt_nx;
  logic o_rsp_valid, i_rsp_ready, o_rsp_id, o_rsp_err, i_fflags_clr;
  logic [TAG_W-1:0] o_rsp_tag;
  logic [4:0] o_rsp_fflags, o_fflags_acc;

  int n_tests = 0;
  int n_fail  = 0;
  int n_start = 0;
  int n_rspv  = 0;
  int cnt     = 0;
  logic model_en;
  int s0, r0;

  fp_cvt_arbiter #(.XLEN(XLEN), .FLEN(FLEN), .TAG_W(TAG_W), .TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready), .i_req0_op(i_req0_op),
    .i_req0_rm(i_req0_rm), .i_req0_int(i_req0_int), .i_req0_fp(i_req0_fp), .i_req0_tag(i_req0_tag),
    .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready), .i_req1_op(i_req1_op),
    .i_req1_rm(i_req1_rm), .i_req1_int(i_req1_int), .i_req1_fp(i_req1_fp), .i_req1_tag(i_req1_tag),
    .i_frm(i_frm), .i_flush(i_flush),
    .o_cvt_start(o_cvt_start), .o_cvt_op(o_cvt_op), .o_cvt_rm(o_cvt_rm),
    .o_cvt_int_op(o_cvt_int_op), .o_cvt_fp_op(o_cvt_fp_op),
    .i_cvt_done(i_cvt_done), .i_cvt_int_res(i_cvt_int_res), .i_cvt_fp_res(i_cvt_fp_res),
    .i_cvt_nv(i_cvt_nv), .i_cvt_nx(i_cvt_nx),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_id(o_rsp_id),
    .o_rsp_tag(o_rsp_tag), .o_rsp_int(o_rsp_int), .o_rsp_fp(o_rsp_fp),
    .o_rsp_fflags(o_rsp_fflags), .o_rsp_err(o_rsp_err),
    .o_fflags_acc(o_fflags_acc), .i_fflags_clr(i_fflags_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Converter results: int 5 -> 5.0f, otherwise a recognisable offset
  always_comb begin
    i_cvt_fp_res  = (o_cvt_int_op == 32'd5) ? 32'h40A0_0000 : o_cvt_int_op + 32'h100;
    i_cvt_int_res = o_cvt_fp_op + 32'd1;
  end

  // Converter model: done pulses three cycles after start
  always @(negedge clk) begin
    i_cvt_done = 1'b0;
    if (cnt != 0) begin
      cnt = cnt - 1;
      if (cnt == 0) i_cvt_done = 1'b1;
    end
    if (o_cvt_start && model_en) cnt = 3;
  end

  // Event counters for start pulses and response-valid cycles
  always @(posedge clk) begin
    if (o_cvt_start) n_start <= n_start + 1;
    if (o_rsp_valid) n_rspv  <= n_rspv + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_rsp(input int max);
    int k;
    k = 0;
    while (!o_rsp_valid && k < max) begin
      step();
      k++;
    end
    chk("rsp_wait", 64'(o_rsp_valid), 64'h1);
  endtask

  task automatic hs();
    i_rsp_ready = 1'b1;
    step();
    i_rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    reset_n = 0; model_en = 1;
    i_req0_valid = 0; i_req0_op = 0; i_req0_rm = 0; i_req0_int = 0; i_req0_fp = 0; i_req0_tag = 0;
    i_req1_valid = 0; i_req1_op = 0; i_req1_rm = 0; i_req1_int = 0; i_req1_fp = 0; i_req1_tag = 0;
    i_frm = 0; i_flush = 0; i_cvt_nv = 0; i_cvt_nx = 0; i_rsp_ready = 0; i_fflags_clr = 0;
    repeat (2) step();
    chk("rst_rsp_valid", 64'(o_rsp_valid), 64'h0);
    chk("rst_cvt_start", 64'(o_cvt_start), 64'h0);
    chk("rst_acc", 64'(o_fflags_acc), 64'h0);
    chk("rst_tag", 64'(o_rsp_tag), 64'h0);
    reset_n = 1;
    step();

    // Basic int->fp conversion latency
    i_req0_valid = 1; i_req0_op = 4'd4; i_req0_int = 32'd5; i_req0_rm = 3'd0; i_req0_tag = 4'd3;
    #1;
    chk("t1_ready0", 64'(o_req0_ready), 64'h1);
    chk("t1_ready1", 64'(o_req1_ready), 64'h0);
    step(); i_req0_valid = 0;
    chk("t1_start", 64'(o_cvt_start), 64'h1);
    chk("t1_cvt_op", 64'(o_cvt_op), 64'h4);
    chk("t1_cvt_int", 64'(o_cvt_int_op), 64'h5);
    step();
    chk("t1_start_pulse", 64'(o_cvt_start), 64'h0);
    step(); step();
    chk("t1_rsp_early", 64'(o_rsp_valid), 64'h0);
    step();
    chk("t1_rsp_valid", 64'(o_rsp_valid), 64'h1);
    chk("t1_rsp_id", 64'(o_rsp_id), 64'h0);
    chk("t1_rsp_tag", 64'(o_rsp_tag), 64'h3);
    chk("t1_rsp_fp", 64'(o_rsp_fp), 64'h40A0_0000);
    chk("t1_rsp_err", 64'(o_rsp_err), 64'h0);
    hs();
    chk("t1_rsp_drop", 64'(o_rsp_valid), 64'h0);

    // Round robin with both requesters continuously valid
    do_reset();
    i_req0_valid = 1; i_req0_op = 4'd4; i_req0_int = 32'd10; i_req0_rm = 3'd0; i_req0_tag = 4'hA;
    i_req1_valid = 1; i_req1_op = 4'd4; i_req1_int = 32'd20; i_req1_rm = 3'd1; i_req1_tag = 4'hB;
    for (int i = 0; i < 4; i++) begin
      wait_rsp(12);
      chk("rr_id", 64'(o_rsp_id), 64'(i % 2));
      chk("rr_tag", 64'(o_rsp_tag), (i % 2 == 1) ? 64'hB : 64'hA);
      chk("rr_fp", 64'(o_rsp_fp), (i % 2 == 1) ? 64'h114 : 64'h10A);
      if (i == 3) begin i_req0_valid = 0; i_req1_valid = 0; end
      hs();
    end

    // Dynamic rounding: legal frm is forwarded, reserved frm is illegal
    i_req1_valid = 1; i_req1_op = 4'd4; i_req1_int = 32'd7; i_req1_rm = 3'b111; i_req1_tag = 4'd5; i_frm = 3'b001;
    step(); i_req1_valid = 0;
    chk("dyn_start", 64'(o_cvt_start), 64'h1);
    chk("dyn_rm", 64'(o_cvt_rm), 64'h1);
    wait_rsp(10);
    chk("dyn_err", 64'(o_rsp_err), 64'h0);
    hs();
    s0 = n_start;
    i_frm = 3'b101; i_req1_valid = 1; i_req1_tag = 4'd6;
    step(); i_req1_valid = 0;
    chk("dynbad_valid", 64'(o_rsp_valid), 64'h1);
    chk("dynbad_err", 64'(o_rsp_err), 64'h1);
    chk("dynbad_fflags", 64'(o_rsp_fflags), 64'h10);
    chk("dynbad_tag", 64'(o_rsp_tag), 64'h6);
    chk("dynbad_fp", 64'(o_rsp_fp), 64'h0);
    hs();
    chk("dynbad_nostart", 64'(n_start), 64'(s0));
    chk("dynbad_acc", 64'(o_fflags_acc), 64'h10);
    i_frm = 3'b000;

    // Illegal op (64-bit integer form on XLEN=32) and reserved static rm
    i_req0_valid = 1; i_req0_op = 4'd2; i_req0_rm = 3'd0; i_req0_tag = 4'd7;
    step(); i_req0_valid = 0;
    chk("illop_valid", 64'(o_rsp_valid), 64'h1);
    chk("illop_err", 64'(o_rsp_err), 64'h1);
    hs();
    i_req0_valid = 1; i_req0_op = 4'd4; i_req0_rm = 3'b101;
    step(); i_req0_valid = 0;
    chk("illrm_err", 64'(o_rsp_err), 64'h1);
    hs();
    chk("ill_nostart", 64'(n_start), 64'(s0));

    // Flush one cycle after start; late done must be absorbed
    i_req0_valid = 1; i_req0_op = 4'd4; i_req0_int = 32'd9; i_req0_rm = 3'd0; i_req0_tag = 4'd8;
    step(); i_req0_valid = 0;
    chk("fl_start", 64'(o_cvt_start), 64'h1);
    r0 = n_rspv;
    step(); i_flush = 1;
    step(); i_flush = 0;
    repeat (4) step();
    chk("fl_no_rsp", 64'(n_rspv), 64'(r0));
    chk("fl_rsp_low", 64'(o_rsp_valid), 64'h0);
    i_flush = 1; i_req0_valid = 1; i_req0_int = 32'd11; i_req0_tag = 4'd9;
    #1;
    chk("fl_idle_block", 64'(o_req0_ready), 64'h0);
    step(); i_flush = 0;
    chk("fl_idle_nostart", 64'(o_cvt_start), 64'h0);
    #1;
    chk("fl_regrant", 64'(o_req0_ready), 64'h1);
    step(); i_req0_valid = 0;
    chk("fl2_start", 64'(o_cvt_start), 64'h1);
    step(); step(); step();
    chk("fl2_rsp_early", 64'(o_rsp_valid), 64'h0);
    step();
    chk("fl2_rsp_valid", 64'(o_rsp_valid), 64'h1);
    chk("fl2_tag", 64'(o_rsp_tag), 64'h9);
    chk("fl2_fp", 64'(o_rsp_fp), 64'h10B);
    hs();

    // Watchdog: converter never answers
    model_en = 0;
    i_req0_valid = 1; i_req0_int = 32'd1; i_req0_tag = 4'hC;
    step(); i_req0_valid = 0;
    chk("to_start", 64'(o_cvt_start), 64'h1);
    repeat (16) step();
    chk("to_early", 64'(o_rsp_valid), 64'h0);
    step();
    chk("to_valid", 64'(o_rsp_valid), 64'h1);
    chk("to_err", 64'(o_rsp_err), 64'h1);
    chk("to_fflags", 64'(o_rsp_fflags), 64'h10);
    hs();
    model_en = 1;

    // Inexact result with clear on the handshake cycle, then plain clear
    i_cvt_nx = 1;
    i_req0_valid = 1; i_req0_int = 32'd2; i_req0_tag = 4'hD;
    step(); i_req0_valid = 0;
    wait_rsp(10);
    chk("nx_fflags", 64'(o_rsp_fflags), 64'h01);
    i_fflags_clr = 1;
    hs();
    i_fflags_clr = 0;
    chk("nx_acc", 64'(o_fflags_acc), 64'h01);
    i_fflags_clr = 1;
    step();
    i_fflags_clr = 0;
    chk("clr_acc", 64'(o_fflags_acc), 64'h00);
    i_cvt_nx = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
